// File: rtl/multiplier_pkg.sv
// ============================================================================
// Module   : multiplier_pkg
// Brief    : Shared FSM states and BCD digit-count helpers for the multiplier.
// Revision : 1.0
// ============================================================================
`default_nettype none

package multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digits needed for a W-bit binary value: 2^W - 1 < 10^(floor(W/3)+1).
  function automatic int bcd_digits_w(input int w);
    return w / 3 + 1;
  endfunction

  // Digits needed for the 2N-bit product of two N-bit operands.
  function automatic int bcd_digits(input int n);
    return bcd_digits_w(2 * n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/multiplier_bin2bcd.sv
// ============================================================================
// Module   : multiplier_bin2bcd
// Brief    : bin2bcd - combinational double-dabble (shift-add-3) converter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multiplier_bin2bcd
  import multiplier_pkg::*;
#(
  parameter int W = 10
) (
  input  logic [W-1:0]                  i_bin,
  output logic [bcd_digits_w(W)*4-1:0]  o_bcd
);

  localparam int c_digits = bcd_digits_w(W);
  localparam int c_bw     = c_digits * 4;

  logic [c_bw-1:0] w_acc;

  always_comb begin
    w_acc = '0;
    for (int i = W - 1; i >= 0; i--) begin
      for (int d = 0; d < c_digits; d++) begin
        if (w_acc[d*4 +: 4] >= 4'd5) begin
          w_acc[d*4 +: 4] = w_acc[d*4 +: 4] + 4'd3;
        end
      end
      w_acc = {w_acc[c_bw-2:0], i_bin[i]};
    end
  end

  assign o_bcd = w_acc;

endmodule

`default_nettype wire

// File: rtl/multiplier.sv
// ============================================================================
// Module   : multiplier
// Brief    : Sequential N-step shift-and-add unsigned multiplier with BCD view.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multiplier
  import multiplier_pkg::*;
#(
  parameter int N = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N-1:0]                 a_in,
  input  logic [N-1:0]                 b_in,
  input  logic                         start,
  output logic [2*N-1:0]               out,
  output logic                         finish,
  output logic [bcd_digits(N)*4-1:0]   bcd
);

  localparam int              c_cw   = $clog2(N + 1);
  localparam logic [c_cw-1:0] c_last = c_cw'(N - 1);

  state_t           r_state;
  logic [2*N-1:0]   r_mcand;
  logic [2*N-1:0]   r_acc;
  logic [N-1:0]     r_mplier;
  logic [c_cw-1:0]  r_count;
  logic [2*N-1:0]   w_sum;

  // Accumulator value including this step's conditional add.
  assign w_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      out      <= '0;
      finish   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          finish <= 1'b0;
          if (start) begin
            r_mcand  <= {{N{1'b0}}, a_in};
            r_mplier <= b_in;
            r_acc    <= '0;
            r_count  <= '0;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          r_acc    <= w_sum;
          r_mcand  <= {r_mcand[2*N-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[N-1:1]};
          r_count  <= r_count + 1'b1;
          if (r_count == c_last) begin
            out     <= w_sum;
            finish  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          // A held start never retriggers; it must drop first.
          if (!start) begin
            finish  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          finish  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  multiplier_bin2bcd #(
    .W (2 * N)
  ) u_bin2bcd (
    .i_bin (out),
    .o_bcd (bcd)
  );

endmodule

`default_nettype wire

// File: tb/tb_multiplier.sv
// ============================================================================
// Module   : tb_multiplier
// Brief    : Scoreboard bench for multiplier at N=5 and N=8.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_multiplier;

  logic        clk;
  logic        reset;
  logic [4:0]  a5, b5;
  logic        start5;
  logic [9:0]  out5;
  logic        fin5;
  logic [15:0] bcd5;
  logic [7:0]  a8, b8;
  logic        start8;
  logic [15:0] out8;
  logic        fin8;
  logic [23:0] bcd8;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] q5[$];
  logic [63:0] q8[$];

  multiplier #(.N(5)) u_dut5 (
    .clk (clk), .reset (reset), .a_in (a5), .b_in (b5), .start (start5),
    .out (out5), .finish (fin5), .bcd (bcd5)
  );

  multiplier #(.N(8)) u_dut8 (
    .clk (clk), .reset (reset), .a_in (a8), .b_in (b8), .start (start8),
    .out (out8), .finish (fin8), .bcd (bcd8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [63:0] to_bcd(input logic [63:0] v);
    logic [63:0] r = '0;
    logic [63:0] x = v;
    for (int d = 0; d < 16; d++) begin
      r = r | ((x % 10) << (4 * d));
      x = x / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop and compare on each rising finish.
  logic fin5_q = 1'b0;
  logic fin8_q = 1'b0;
  always begin
    logic [63:0] e;
    @(posedge clk);
    #2;
    if (fin5 === 1'b1 && !fin5_q) begin
      if (q5.size() == 0) check("q5_underflow", 64'd1, 64'd0);
      else begin
        e = q5.pop_front();
        check("out5", {54'd0, out5}, e);
        check("bcd5", {48'd0, bcd5}, to_bcd(e));
      end
    end
    if (fin8 === 1'b1 && !fin8_q) begin
      if (q8.size() == 0) check("q8_underflow", 64'd1, 64'd0);
      else begin
        e = q8.pop_front();
        check("out8", {48'd0, out8}, e);
        check("bcd8", {40'd0, bcd8}, to_bcd(e));
      end
    end
    fin5_q = (fin5 === 1'b1);
    fin8_q = (fin8 === 1'b1);
  end

  // One full operation: load, latency check, held-start and input-change
  // immunity, then re-arm. Called just after a tick with start low.
  task automatic op(input int sel, input logic [63:0] a, input logic [63:0] b);
    int          n;
    logic [63:0] exp;
    logic [63:0] f;
    logic [63:0] o;
    n   = (sel == 0) ? 5 : 8;
    exp = a * b;
    if (sel == 0) begin a5 = a[4:0]; b5 = b[4:0]; start5 = 1'b1; q5.push_back(exp); end
    else          begin a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1; q8.push_back(exp); end
    tick();
    for (int k = 1; k <= n; k++) begin
      if (k == 2) begin
        a5 = 5'($urandom); b5 = 5'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      end
      tick();
      f = (sel == 0) ? {63'd0, fin5} : {63'd0, fin8};
      check("latency_finish", f, (k == n) ? 64'd1 : 64'd0);
    end
    for (int h = 0; h < 2; h++) begin
      a5 = 5'($urandom); b5 = 5'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      tick();
      f = (sel == 0) ? {63'd0, fin5} : {63'd0, fin8};
      o = (sel == 0) ? {54'd0, out5} : {48'd0, out8};
      check("hold_finish", f, 64'd1);
      check("hold_out", o, exp);
    end
    if (sel == 0) start5 = 1'b0; else start8 = 1'b0;
    tick();
    f = (sel == 0) ? {63'd0, fin5} : {63'd0, fin8};
    o = (sel == 0) ? {54'd0, out5} : {48'd0, out8};
    check("rearm_finish", f, 64'd0);
    check("rearm_out", o, exp);
  endtask

  initial begin
    reset = 1'b0; start5 = 1'b1; start8 = 1'b1;
    a5 = 5'd26; b5 = 5'd30; a8 = 8'd7; b8 = 8'd9;
    tick();
    tick();
    check("rst_out5", {54'd0, out5}, 64'd0);
    check("rst_fin5", {63'd0, fin5}, 64'd0);
    check("rst_bcd5", {48'd0, bcd5}, 64'd0);
    check("rst_fin8", {63'd0, fin8}, 64'd0);
    reset = 1'b1; start5 = 1'b0; start8 = 1'b0;
    repeat (7) tick();
    check("no_op_in_reset", {63'd0, fin5}, 64'd0);
    check("idle_out5", {54'd0, out5}, 64'd0);

    op(0, 26, 30);
    check("bcd_780", {48'd0, bcd5}, 64'h0780);
    op(0, 13, 13);
    check("bcd_169", {48'd0, bcd5}, 64'h0169);
    op(0, 31, 31);
    check("bcd_961", {48'd0, bcd5}, 64'h0961);
    op(0, 0, 31);
    check("bcd_zero", {48'd0, bcd5}, 64'h0000);
    op(0, 1, 1);
    check("bcd_one", {48'd0, bcd5}, 64'h0001);

    // Abort at BUSY edge 3: no result, back to idle.
    a5 = 5'd21; b5 = 5'd17; start5 = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("abort_out", {54'd0, out5}, 64'd0);
    check("abort_fin", {63'd0, fin5}, 64'd0);
    reset = 1'b1; start5 = 1'b0;
    repeat (7) tick();
    check("abort_idle", {63'd0, fin5}, 64'd0);
    op(0, 21, 17);

    op(1, 255, 255);
    op(1, 0, 200);
    for (int i = 0; i < 6; i++) op(1, 64'($urandom_range(255)), 64'($urandom_range(255)));

    repeat (3) tick();
    check("q5_empty", 64'(q5.size()), 64'd0);
    check("q8_empty", 64'(q8.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multiplier.md
Name: multiplier

Overview:
- Sequential unsigned shift-and-add multiplier with BCD output.
- Takes two N-bit unsigned operands on a start request and produces the 2N-bit binary product in N add/shift cycles.
- Also presents the product as packed BCD digits, using a combinational double-dabble (shift-add-3) converter.
- Used as a standalone arithmetic block feeding decimal display or readout logic.

Parameters:
- N, 5, operand width in bits (N ≥ 2). Product width is 2N. BCD width is (floor(2N/3)+1)*4 bits.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  synchronous, active-low reset.
- a_in  input  N  multiplicand, unsigned.
- b_in  input  N  multiplier, unsigned.
- start  input  1  level request to begin a multiplication.
- out  output  2N  registered binary product a_in*b_in.
- finish  output  1  registered done flag.
- bcd  output  (floor(2N/3)+1)*4  packed BCD of out; least-significant digit in bits [3:0].

Behaviour:
- Reset:
  - One clock, synchronous, active-low: reset sampled low at a rising edge forces state=IDLE, out=0, finish=0 and clears internal registers.
  - bcd therefore reads 0.
  - Reset low mid-operation aborts the operation with no partial result.
- States: IDLE, BUSY, DONE.
- IDLE:
  - finish=0; out holds its last value.
  - If start=1 at a rising edge (the load edge): latch a_in into the multiplicand register (zero-extended to 2N), latch b_in into the multiplier shift register, clear the accumulator and the step counter, go to BUSY.
- BUSY:
  - Each edge: if the multiplier LSB is 1, add the multiplicand to the accumulator (2N-bit, no overflow possible). Then shift the multiplicand left 1 and the multiplier right 1, and increment the counter.
  - On the Nth BUSY edge (N edges after the load edge): write out = accumulator including this step's addition, set finish=1, go to DONE.
  - a_in, b_in and start changes during BUSY are ignored.
  - out keeps the previous result until the completing edge.
- DONE:
  - finish=1; out stable.
  - Remains in DONE while start=1; a held start never retriggers.
  - When start=0 at an edge: finish<=0, go to IDLE.
  - A new operation requires start low for at least one edge, then high.
- Latency: finish and out become valid N clock edges after the load edge. For N=5 that is 5 edges.
- bcd:
  - Purely combinational function of out, via double dabble.
  - For each of the 2N input bits, MSB first: add 3 to every BCD digit ≥ 5, then shift left, bringing in the next bit.
  - Digit count floor(2N/3)+1 always suffices, because 2^(2N)−1 < 10^(floor(2N/3)+1).
  - Unused upper digits read 0.
- All arithmetic is unsigned. Zero operands are legal. The maximum product is (2^N−1)^2.

Decomposition:
- Shared package:
  - function bcd_digits(N) = floor(2N/3)+1.
  - state enum IDLE/BUSY/DONE.
- One natural sub-module: bin2bcd, a combinational double-dabble converter with parameter W (binary width) and output width bcd_digits*4; instantiated on out.
- The multiply datapath and FSM stay in multiplier.

Test Plan:
- Reset: hold reset=0 for 2 edges with start=1 → out=0, finish=0, bcd=0; no operation starts while reset is low.
- Basic, N=5: a_in=26, b_in=30, start 0→1 → exactly 5 edges after the load edge: out=780 (10'h30C), bcd=16'h0780, finish=1.
  - finish stays 1 while start is held high.
  - Changing a_in/b_in during BUSY or DONE does not alter out.
- Re-arm: drop start to 0 → finish=0 on the next edge, out holds 780. Then a_in=13, b_in=13, start 0→1 → out=169, bcd=16'h0169, finish=1 after 5 edges.
- Boundaries:
  - a_in=31, b_in=31 → out=961, bcd=16'h0961.
  - a_in=0, b_in=31 → out=0, bcd=0, finish=1 after 5 edges.
  - a_in=1, b_in=1 → out=1, bcd=16'h0001.
- Reset mid-operation: start an operation, assert reset at BUSY edge 3 → out=0, finish=0, state IDLE. A subsequent start completes normally with the correct product.
- Parameter sweep: N=8, random operands → out equals a_in*b_in; bcd decodes back to out; latency is exactly 8 edges; bcd width is 24 bits (6 digits).
